mux_scan_ctrl: RTL and testbench

MUX_SCAN_CTRL -- requirements
Module: mux_scan_ctrl

---
 rtl/mux_scan_ctrl.sv | 146 ++++++++++++++
 tb/tb_mux_scan_ctrl.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mux_scan_ctrl.sv
// mux_scan_ctrl: round-robin scan controller for a downstream 4:1 mux.
// Grants one requesting channel at a time and drives its select. After a
// settle interval it captures the returned bit and presents it with a
// valid/ready handshake.
// Optional feature macro: MUX_SCAN_DWELL_EN. When defined, the settle
// interval comes from the dwell port (0 treated as 1). Otherwise it is
// fixed at one cycle and dwell is ignored.
module mux_scan_ctrl #(
    parameter int DWELL_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               enable,
    input  logic [3:0]         req,
    input  logic [DWELL_W-1:0] dwell,
    input  logic               y_in,
    output logic [1:0]         sel,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               out_bit,
    output logic [1:0]         out_ch,
    output logic               busy
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SETTLE  = 2'd1,
        PRESENT = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_next_state;
    logic [1:0]         r_sel;
    logic               r_valid;
    logic               r_bit;
    logic [1:0]         r_ch;
    logic [1:0]         r_last;
    logic [DWELL_W-1:0] r_cnt;

    logic               w_grant;
    logic               w_capture;
    logic               w_handshake;
    logic [1:0]         w_base;
    logic [1:0]         w_pick;
    logic [DWELL_W-1:0] w_d;

    // First set request strictly after 'last', wrapping 3->0; 'last' itself
    // is chosen only when it is the sole requester.
    function automatic logic [1:0] f_pick(input logic [3:0] r, input logic [1:0] last);
        logic [1:0] v_c;
        f_pick = last;
        for (int i = 4; i >= 1; i--) begin
            v_c = last + 2'(i);
            if (r[v_c]) f_pick = v_c;
        end
    endfunction

`ifdef MUX_SCAN_DWELL_EN
    assign w_d = (dwell == '0) ? DWELL_W'(1) : dwell;
`else
    logic w_unused_dwell;
    assign w_d = DWELL_W'(1);
    assign w_unused_dwell = ^dwell;
`endif

    // On a handshake edge the just-delivered channel becomes the arbitration
    // base, so the immediate regrant already sees the updated last channel.
    assign w_pick = f_pick(req, w_base);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next_state;
    end

    // Next-state and per-edge action decode.
    always_comb begin
        w_next_state = r_state;
        w_grant      = 1'b0;
        w_capture    = 1'b0;
        w_handshake  = 1'b0;
        w_base       = r_last;
        case (r_state)
            IDLE: begin
                if (enable && (req != 4'd0)) begin
                    w_grant      = 1'b1;
                    w_next_state = SETTLE;
                end
            end
            SETTLE: begin
                if (r_cnt <= DWELL_W'(1)) begin
                    w_capture    = 1'b1;
                    w_next_state = PRESENT;
                end
            end
            PRESENT: begin
                if (r_valid && out_ready) begin
                    w_handshake = 1'b1;
                    w_base      = r_ch;
                    if (enable && (req != 4'd0)) begin
                        w_grant      = 1'b1;
                        w_next_state = SETTLE;
                    end else begin
                        w_next_state = IDLE;
                    end
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    // Select, settle counter, captured sample and round-robin pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sel   <= 2'd0;
            r_valid <= 1'b0;
            r_bit   <= 1'b0;
            r_ch    <= 2'd0;
            r_last  <= 2'd3;
            r_cnt   <= '0;
        end else begin
            if (w_grant) begin
                r_sel <= w_pick;
                r_cnt <= w_d;
            end else if (r_state == SETTLE) begin
                r_cnt <= r_cnt - DWELL_W'(1);
            end
            if (w_capture) begin
                r_bit   <= y_in;
                r_ch    <= r_sel;
                r_valid <= 1'b1;
            end
            if (w_handshake) begin
                r_valid <= 1'b0;
                r_last  <= r_ch;
            end
        end
    end

    assign sel       = r_sel;
    assign out_valid = r_valid;
    assign out_bit   = r_bit;
    assign out_ch    = r_ch;
    assign busy      = (r_state != IDLE);

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Directed testbench for mux_scan_ctrl. Models the downstream 4:1 mux as
// y_in = mux_data[sel]. Outputs are observed 1 time unit after each rising
// edge, packed as {out_valid, out_bit, out_ch, sel, busy}.
module tb_mux_scan_ctrl;

    logic       clk;
    logic       rst_n;
    logic       enable;
    logic [3:0] req;
    logic [3:0] dwell;
    logic       y_in;
    logic [1:0] sel;
    logic       out_valid;
    logic       out_ready;
    logic       out_bit;
    logic [1:0] out_ch;
    logic       busy;
    logic [3:0] mux_data;

    int n_vec;
    int n_err;

    wire [6:0] obs = {out_valid, out_bit, out_ch, sel, busy};

    assign y_in = mux_data[sel];

    mux_scan_ctrl #(.DWELL_W(4)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .enable   (enable),
        .req      (req),
        .dwell    (dwell),
        .y_in     (y_in),
        .sel      (sel),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_bit  (out_bit),
        .out_ch   (out_ch),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        logic [6:0] exp;
        rst_n = 1'b0;
        #1;
        exp = 7'b0;
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL reset_state: got %b expected %b", obs, exp);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL reset_idle_no_req: got %b expected %b", obs, exp);
        end
    endtask

    task automatic test_single();
        logic [6:0] exp;
        do_reset();
        enable = 1'b1; req = 4'b0001; mux_data = 4'b0001; out_ready = 1'b1; dwell = 4'd1;
        tick();
        exp = {1'b0, 1'b0, 2'd0, 2'd0, 1'b1};
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL single_grant: got %b expected %b", obs, exp);
        end
        tick();
        exp = {1'b1, 1'b1, 2'd0, 2'd0, 1'b1};
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL single_sample: got %b expected %b", obs, exp);
        end
        req = 4'b0000;
        tick();
        exp = {1'b0, 1'b1, 2'd0, 2'd0, 1'b0};
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL single_to_idle: got %b expected %b", obs, exp);
        end
    endtask

    task automatic test_full_scan();
        logic [6:0] exp;
        logic [1:0] ch;
        logic       pb, eb;
        logic [1:0] pc;
        do_reset();
        enable = 1'b1; req = 4'b1111; mux_data = 4'h5; out_ready = 1'b1; dwell = 4'd1;
        pb = 1'b0; pc = 2'd0;
        for (int k = 0; k < 5; k++) begin
            ch = 2'(k % 4);
            tick();
            exp = {1'b0, pb, pc, ch, 1'b1};
            n_vec++;
            if (obs !== exp) begin
                n_err++;
                $display("FAIL scan_grant_%0d: got %b expected %b", k, obs, exp);
            end
            tick();
            eb = mux_data[ch];
            exp = {1'b1, eb, ch, ch, 1'b1};
            n_vec++;
            if (obs !== exp) begin
                n_err++;
                $display("FAIL scan_sample_%0d: got %b expected %b", k, obs, exp);
            end
            pb = eb; pc = ch;
        end
        req = 4'b0000;
        tick();
        exp = {1'b0, pb, pc, pc, 1'b0};
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL scan_end_idle: got %b expected %b", obs, exp);
        end
    endtask

    task automatic test_backpressure();
        logic [6:0] exp;
        do_reset();
        enable = 1'b1; req = 4'b0100; mux_data = 4'b0100; out_ready = 1'b0; dwell = 4'd1;
        tick();
        tick();
        exp = {1'b1, 1'b1, 2'd2, 2'd2, 1'b1};
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL bp_sample: got %b expected %b", obs, exp);
        end
        mux_data = 4'b0000; req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            tick();
            n_vec++;
            if (obs !== exp) begin
                n_err++;
                $display("FAIL bp_hold_%0d: got %b expected %b", k, obs, exp);
            end
        end
        out_ready = 1'b1; req = 4'b0000;
        tick();
        exp = {1'b0, 1'b1, 2'd2, 2'd2, 1'b0};
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL bp_release: got %b expected %b", obs, exp);
        end
    endtask

    task automatic test_skip_wrap();
        logic [6:0] exp;
        do_reset();
        enable = 1'b1; req = 4'b0010; mux_data = 4'b1010; out_ready = 1'b1; dwell = 4'd1;
        tick();
        tick();
        exp = {1'b1, 1'b1, 2'd1, 2'd1, 1'b1};
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL skip_first_ch1: got %b expected %b", obs, exp);
        end
        req = 4'b1010;
        tick();
        exp = {1'b0, 1'b1, 2'd1, 2'd3, 1'b1};
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL skip_grant_ch3: got %b expected %b", obs, exp);
        end
        tick();
        tick();
        exp = {1'b0, 1'b1, 2'd3, 2'd1, 1'b1};
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL wrap_grant_ch1: got %b expected %b", obs, exp);
        end
        tick();
        req = 4'b0010;
        tick();
        exp = {1'b0, 1'b1, 2'd1, 2'd1, 1'b1};
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL sole_repeat_ch1: got %b expected %b", obs, exp);
        end
        req = 4'b0000;
        tick();
        tick();
    endtask

    task automatic test_reset_mid_transfer();
        logic [6:0] exp;
        do_reset();
        enable = 1'b1; req = 4'b0100; mux_data = 4'b1000; out_ready = 1'b0; dwell = 4'd1;
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        exp = 7'b0;
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL rst_mid_settle_async: got %b expected %b", obs, exp);
        end
        req = 4'b1000;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        exp = {1'b0, 1'b0, 2'd0, 2'd3, 1'b1};
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL rst_first_grant_ch3: got %b expected %b", obs, exp);
        end
        tick();
        exp = {1'b1, 1'b1, 2'd3, 2'd3, 1'b1};
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL rst_grant_sample: got %b expected %b", obs, exp);
        end
        #2;
        rst_n = 1'b0;
        #1;
        exp = 7'b0;
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL rst_mid_present_async: got %b expected %b", obs, exp);
        end
        req = 4'b0000; out_ready = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL rst_no_stale_valid: got %b expected %b", obs, exp);
        end
    endtask

`ifdef MUX_SCAN_DWELL_EN
    task automatic test_dwell();
        logic [6:0] exp;
        do_reset();
        enable = 1'b1; req = 4'b0001; mux_data = 4'b0001; out_ready = 1'b1; dwell = 4'd3;
        tick();
        dwell = 4'd0;
        exp = {1'b0, 1'b0, 2'd0, 2'd0, 1'b1};
        for (int k = 1; k <= 2; k++) begin
            tick();
            n_vec++;
            if (obs !== exp) begin
                n_err++;
                $display("FAIL dwell3_wait_%0d: got %b expected %b", k, obs, exp);
            end
        end
        req = 4'b0000;
        tick();
        exp = {1'b1, 1'b1, 2'd0, 2'd0, 1'b1};
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL dwell3_sample: got %b expected %b", obs, exp);
        end
        tick();
        req = 4'b0001;
        tick();
        tick();
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL dwell0_sample: got %b expected %b", obs, exp);
        end
        req = 4'b0000;
        tick();
    endtask
`else
    task automatic test_dwell();
        logic [6:0] exp;
        do_reset();
        enable = 1'b1; req = 4'b0001; mux_data = 4'b0001; out_ready = 1'b1; dwell = 4'd7;
        tick();
        tick();
        exp = {1'b1, 1'b1, 2'd0, 2'd0, 1'b1};
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL dwell_ignored: got %b expected %b", obs, exp);
        end
        req = 4'b0000;
        tick();
    endtask
`endif

    initial begin
        n_vec = 0;
        n_err = 0;
        rst_n = 1'b0;
        enable = 1'b0;
        req = 4'b0000;
        dwell = 4'd1;
        mux_data = 4'b0000;
        out_ready = 1'b0;
        test_reset();
        test_single();
        test_full_scan();
        test_backpressure();
        test_skip_wrap();
        test_reset_mid_transfer();
        test_dwell();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
